// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock front end.
// Holds the FSM state encodings and the default idle code value.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    EMIT
  } entry_state_t;

  typedef enum logic [1:0] {
    REL,
    PWAIT,
    HELD,
    RWAIT
  } deb_state_t;

  // Never matches any lock code byte, so the lock ignores it.
  localparam logic [7:0] DEFAULT_IDLE_CODE = 8'h00;

endpackage

// File: rtl/key_debounce.sv
// Keypad debouncer: emits one registered press event (ev/ev_val) per
// physical press once key_down and key_val are stable for DEBOUNCE cycles.
module key_debounce
  import lock_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_down,
  input  logic [3:0] key_val,
  output logic       ev,
  output logic [3:0] ev_val
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  deb_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    cap_reg, cap_next;
  logic          ev_reg, ev_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= REL;
      cnt_reg   <= '0;
      cap_reg   <= '0;
      ev_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cap_reg   <= cap_next;
      ev_reg    <= ev_next;
    end
  end

  // The cycle that enters PWAIT/RWAIT already counts as the first stable cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cap_next   = cap_reg;
    ev_next    = 1'b0;
    unique case (state_reg)
      REL: begin
        cnt_next = '0;
        if (key_down) begin
          cap_next = key_val;
          if (DEBOUNCE == 1) begin
            state_next = HELD;
            ev_next    = 1'b1;
          end else begin
            state_next = PWAIT;
            cnt_next   = CNT_ONE;
          end
        end
      end
      PWAIT: begin
        if (!key_down) begin
          state_next = REL;
          cnt_next   = '0;
        end else if (key_val != cap_reg) begin
          cap_next = key_val;
          cnt_next = CNT_ONE;
        end else if (cnt_reg >= CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          ev_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HELD: begin
        cnt_next = '0;
        if (!key_down) begin
          if (DEBOUNCE == 1) begin
            state_next = REL;
          end else begin
            state_next = RWAIT;
            cnt_next   = CNT_ONE;
          end
        end
      end
      RWAIT: begin
        if (key_down) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg >= CNT_LAST) begin
          state_next = REL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = REL;
        cnt_next   = '0;
      end
    endcase
  end

  assign ev     = ev_reg;
  assign ev_val = cap_reg;

endmodule

// File: rtl/code_entry.sv
// Pairs two debounced hex keys into one code byte, strobed for one cycle;
// a partial entry is dropped on key_clear or after TIMEOUT cycles.
module code_entry
  import lock_pkg::*;
#(
  parameter int         DEBOUNCE  = 4,
  parameter int         TIMEOUT   = 100,
  parameter logic [7:0] IDLE_CODE = DEFAULT_IDLE_CODE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_down,
  input  logic [3:0] key_val,
  input  logic       key_clear,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       nibble_pend,
  output logic       err_timeout
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  logic       ev;
  logic [3:0] ev_val;

  key_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .key_down(key_down),
    .key_val (key_val),
    .ev      (ev),
    .ev_val  (ev_val)
  );

  entry_state_t  state_reg, state_next;
  logic [3:0]    hi_reg, hi_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [7:0]    code_reg, code_next;
  logic          code_valid_reg, code_valid_next;
  logic          nibble_pend_reg, nibble_pend_next;
  logic          err_timeout_reg, err_timeout_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      hi_reg          <= '0;
      tmo_reg         <= '0;
      code_reg        <= IDLE_CODE;
      code_valid_reg  <= 1'b0;
      nibble_pend_reg <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hi_reg          <= hi_next;
      tmo_reg         <= tmo_next;
      code_reg        <= code_next;
      code_valid_reg  <= code_valid_next;
      nibble_pend_reg <= nibble_pend_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  // Outputs are computed for the state being entered so they are registered
  // and aligned with it: code/code_valid are only asserted while in EMIT.
  always_comb begin
    state_next       = state_reg;
    hi_next          = hi_reg;
    tmo_next         = tmo_reg;
    code_next        = IDLE_CODE;
    code_valid_next  = 1'b0;
    err_timeout_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (ev) begin
          hi_next    = ev_val;
          tmo_next   = '0;
          state_next = HIGH;
        end
      end
      HIGH: begin
        // Priority: clear, then the low nibble, then expiry.
        if (key_clear) begin
          state_next = IDLE;
        end else if (ev) begin
          code_next       = {hi_reg, ev_val};
          code_valid_next = 1'b1;
          state_next      = EMIT;
        end else if (tmo_reg >= TMO_LAST) begin
          err_timeout_next = 1'b1;
          state_next       = IDLE;
        end else begin
          tmo_next = tmo_reg + TMO_ONE;
        end
      end
      EMIT: begin
        if (ev) begin
          hi_next    = ev_val;
          tmo_next   = '0;
          state_next = HIGH;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    nibble_pend_next = (state_next == HIGH);
  end

  assign code        = code_reg;
  assign code_valid  = code_valid_reg;
  assign nibble_pend = nibble_pend_reg;
  assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_code_entry.sv
// Self-checking bench for code_entry: a scoreboard queue holds expected
// code bytes with their due cycle; a monitor pops them on code_valid.
module tb_code_entry;
  import lock_pkg::*;

  localparam logic [7:0] IDLE_CODE = 8'h00;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_down = 1'b0;
  logic [3:0] key_val = 4'h0;
  logic       key_clear = 1'b0;
  logic [7:0] code;
  logic       code_valid;
  logic       nibble_pend;
  logic       err_timeout;

  code_entry #(
    .DEBOUNCE (4),
    .TIMEOUT  (100),
    .IDLE_CODE(IDLE_CODE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_down   (key_down),
    .key_val    (key_val),
    .key_clear  (key_clear),
    .code       (code),
    .code_valid (code_valid),
    .nibble_pend(nibble_pend),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ev_seen = 0;
  int   valid_seen = 0;
  int   err_seen = 0;

  // Downstream lock: advances on aa, bb, cc in order; anything else holds.
  logic [1:0] lock_state;
  logic       unlocked;
  always @(posedge clk) begin
    if (!reset_n) lock_state <= 2'b00;
    else if (code_valid) begin
      if (lock_state == 2'b00 && code == 8'hAA) lock_state <= 2'b01;
      else if (lock_state == 2'b01 && code == 8'hBB) lock_state <= 2'b10;
      else if (lock_state == 2'b10 && code == 8'hCC) lock_state <= 2'b11;
    end
  end
  assign unlocked = (lock_state == 2'b11);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (dut.u_debounce.ev) ev_seen++;
    if (err_timeout) err_seen++;
    checks++;
    if (code_valid) begin
      valid_seen++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_code: cyc=%0d code=%h code_valid=1, required no strobe", cyc, code);
      end else begin
        e = sb.pop_front();
        if (code !== e.code || cyc != e.due) begin
          errors++;
          $display("FAIL code_byte: got %h at cyc %0d, required %h at cyc %0d", code, cyc, e.code, e.due);
        end else
          $display("code %h at cyc %0d ok", code, cyc);
      end
    end else if (code !== IDLE_CODE) begin
      errors++;
      $display("FAIL idle_code: cyc=%0d code=%h, required %h", cyc, code, IDLE_CODE);
    end
  end

  // One key press: held 8 cycles, released 8. Optionally schedules the byte
  // expected DEBOUNCE+1 cycles after the rise.
  task automatic press(input logic [3:0] v, input bit exp_en, input logic [7:0] exp_code,
                       output int rise);
    @(negedge clk);
    key_down = 1'b1;
    key_val  = v;
    rise     = cyc;
    if (exp_en) sb.push_back('{exp_code, cyc + 5});
    repeat (8) @(negedge clk);
    key_down = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (code !== IDLE_CODE || code_valid !== 1'b0 || nibble_pend !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: code=%h v=%b p=%b e=%b, required %h 0 0 0",
               code, code_valid, nibble_pend, err_timeout, IDLE_CODE);
    end else $display("reset outputs ok");
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_press();
    int r, v0;
    v0 = valid_seen;
    press(4'hA, 1'b0, 8'h00, r);
    checks++;
    if (nibble_pend !== 1'b1) begin
      errors++;
      $display("FAIL pend_after_high: nibble_pend=%b, required 1", nibble_pend);
    end
    press(4'hA, 1'b1, 8'hAA, r);
    checks++;
    if (nibble_pend !== 1'b0 || valid_seen - v0 != 1) begin
      errors++;
      $display("FAIL clean_press_aa: nibble_pend=%b strobes=%0d, required 0 and 1", nibble_pend, valid_seen - v0);
    end else $display("clean press AA ok");
  endtask

  task automatic test_bounce();
    int e0, v0;
    e0 = ev_seen;
    v0 = valid_seen;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      key_down = ((i / 2) % 2 == 0);
      key_val  = 4'h3;
    end
    @(negedge clk);
    key_down = 1'b1;
    repeat (8) @(negedge clk);
    key_down = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (ev_seen - e0 != 1 || valid_seen != v0 || nibble_pend !== 1'b1) begin
      errors++;
      $display("FAIL bounce: events=%0d strobes=%0d pend=%b, required 1 0 1",
               ev_seen - e0, valid_seen - v0, nibble_pend);
    end else $display("bounce single event ok");
    pulse_clear();
    checks++;
    if (nibble_pend !== 1'b0) begin
      errors++;
      $display("FAIL bounce_clear: nibble_pend=%b, required 0", nibble_pend);
    end
  endtask

  task automatic test_timeout();
    int r, s0, dummy;
    s0 = err_seen;
    press(4'hB, 1'b0, 8'h00, r);
    while (cyc < r + 104) @(negedge clk);
    checks++;
    if (nibble_pend !== 1'b1 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL pre_timeout: pend=%b err=%b, required 1 0", nibble_pend, err_timeout);
    end
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b1 || nibble_pend !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge: err=%b pend=%b at cyc %0d, required 1 0", err_timeout, nibble_pend, cyc);
    end else $display("timeout at cyc %0d ok", cyc);
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b0 || err_seen - s0 != 1) begin
      errors++;
      $display("FAIL timeout_pulse: err=%b pulses=%0d, required 0 1", err_timeout, err_seen - s0);
    end
    press(4'hC, 1'b0, 8'h00, dummy);
    press(4'hC, 1'b1, 8'hCC, dummy);
  endtask

  task automatic test_clear();
    int r, e0, v0;
    press(4'hA, 1'b0, 8'h00, r);
    pulse_clear();
    checks++;
    if (nibble_pend !== 1'b0) begin
      errors++;
      $display("FAIL clear_pend: nibble_pend=%b, required 0", nibble_pend);
    end
    press(4'hA, 1'b0, 8'h00, r);
    e0 = ev_seen;
    v0 = valid_seen;
    @(negedge clk);
    key_down = 1'b1;
    key_val  = 4'h5;
    repeat (4) @(negedge clk);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    repeat (3) @(negedge clk);
    key_down = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (ev_seen - e0 != 1 || valid_seen != v0 || nibble_pend !== 1'b0) begin
      errors++;
      $display("FAIL clear_vs_ev: events=%0d strobes=%0d pend=%b, required 1 0 0",
               ev_seen - e0, valid_seen - v0, nibble_pend);
    end else $display("clear beats ev ok");
    press(4'h1, 1'b0, 8'h00, r);
    press(4'h2, 1'b1, 8'h12, r);
  endtask

  task automatic test_reset_mid_entry();
    int r;
    press(4'hA, 1'b0, 8'h00, r);
    checks++;
    if (nibble_pend !== 1'b1) begin
      errors++;
      $display("FAIL pend_before_reset: nibble_pend=%b, required 1", nibble_pend);
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (code !== IDLE_CODE || code_valid !== 1'b0 || nibble_pend !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: code=%h v=%b p=%b e=%b, required %h 0 0 0",
               code, code_valid, nibble_pend, err_timeout, IDLE_CODE);
    end else $display("reset mid entry ok");
    press(4'hB, 1'b0, 8'h00, r);
    press(4'hB, 1'b1, 8'hBB, r);
  endtask

  task automatic test_lock();
    int r;
    logic [1:0] want [4];
    logic [7:0] bytes [4];
    want  = '{2'b01, 2'b01, 2'b10, 2'b11};
    bytes = '{8'hAA, 8'hAB, 8'hBB, 8'hCC};
    checks++;
    if (lock_state !== 2'b00) begin
      errors++;
      $display("FAIL lock_start: state=%b, required 00", lock_state);
    end
    for (int i = 0; i < 4; i++) begin
      press(bytes[i][7:4], 1'b0, 8'h00, r);
      press(bytes[i][3:0], 1'b1, bytes[i], r);
      checks++;
      if (lock_state !== want[i]) begin
        errors++;
        $display("FAIL lock_step: byte %h state=%b, required %b", bytes[i], lock_state, want[i]);
      end else $display("lock byte %h state %b ok", bytes[i], lock_state);
    end
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL lock_unlocked: unlocked=%b, required 1", unlocked);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_timeout();
    test_clear();
    test_reset_mid_entry();
    test_lock();
    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d bytes never strobed, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
